// File: rtl/link_credit_scheduler_pkg.sv
// Shared definitions for the NIC-to-router link credit scheduler.
//   - topology constants (buffers, VCs, VNs, downstream buffer depth)
//   - clog2 helper for deriving index widths
//   - FSM state encoding for the wormhole lock
package link_credit_scheduler_pkg;

    localparam int N_FIFO_OUT_BUFFER = 4;
    localparam int N_OF_VC           = 3;
    localparam int N_OF_VN           = 2;
    localparam int MAX_CREDIT        = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter_n.sv
// N-way round-robin priority pick, purely combinational.
//   req_i  : request vector
//   ptr_i  : highest-priority index; search goes ptr, ptr+1, ... modulo N
//   gnt_o  : one-hot grant (all-zero when no request)
//   idx_o  : binary index of the grant (0 when no request)
//   any_o  : some request was granted
module rr_arbiter_n #(
    parameter int N  = 4,
    parameter int NB = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [NB-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [NB-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int c;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[c]) begin
                any_o    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = NB'(c);
            end
        end
    end

endmodule

// File: rtl/link_credit_scheduler.sv
// Shares one flit link between N_REQ output buffers, one flit per cycle.
// Grants only to buffers whose VC has downstream credit, holds the link for
// a whole packet (head..tail), and rotates priority between packets.
//   clk, rst            : clock, async active-low reset
//   r_la_i/r_vc_id_i/
//   r_tail_i            : per-buffer request, allocated VC, tail marker
//   credit_signal_i     : per-VC credit return pulses
//   g_la_o/g_channel_id_o/
//   g_onehot_o          : combinational grant for this cycle
//   locked_o            : a packet currently owns the link
//   credit_count_o      : per-VC credit counters
//   credit_err_o        : sticky credit-overflow flag
module link_credit_scheduler
    import link_credit_scheduler_pkg::*;
#(
    parameter int N_REQ         = N_FIFO_OUT_BUFFER,
    parameter int N_BITS_REQ    = clog2(N_REQ),
    parameter int N_TOT_OF_VC   = N_OF_VC * N_OF_VN,
    parameter int N_BITS_VC     = clog2(N_TOT_OF_VC),
    parameter int MAX_CRED      = MAX_CREDIT,
    parameter int N_BITS_CREDIT = clog2(MAX_CRED + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_REQ-1:0]                     r_la_i,
    input  logic [N_REQ*N_BITS_VC-1:0]           r_vc_id_i,
    input  logic [N_REQ-1:0]                     r_tail_i,
    input  logic [N_TOT_OF_VC-1:0]               credit_signal_i,
    output logic                                 g_la_o,
    output logic [N_BITS_REQ-1:0]                g_channel_id_o,
    output logic [N_REQ-1:0]                     g_onehot_o,
    output logic                                 locked_o,
    output logic [N_TOT_OF_VC*N_BITS_CREDIT-1:0] credit_count_o,
    output logic                                 credit_err_o
);

    state_e                                      state_q, state_d;
    logic [N_BITS_REQ-1:0]                       rr_ptr_q, rr_ptr_d;
    logic [N_BITS_REQ-1:0]                       owner_q, owner_d;
    logic [N_TOT_OF_VC-1:0][N_BITS_CREDIT-1:0]   credit_q, credit_d;
    logic                                        err_q, err_d;

    logic [N_REQ-1:0]      eligible, arb_req, arb_gnt;
    logic [N_BITS_REQ-1:0] arb_idx;
    logic                  arb_any;
    logic [N_BITS_VC-1:0]  win_vc;
    logic                  win_tail;

    // Illegal VC ids never match a counter, so they stay ineligible.
    // Only registered credit counts are used: a same-cycle return does not help.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int v = 0; v < N_TOT_OF_VC; v++) begin
                if (r_la_i[i] && r_vc_id_i[i*N_BITS_VC +: N_BITS_VC] == N_BITS_VC'(v)
                    && credit_q[v] != '0)
                    eligible[i] = 1'b1;
            end
        end
    end

    // While locked only the owner may compete; the pointer then just picks it.
    assign arb_req = (state_q == LOCKED) ? (eligible & (N_REQ'(1) << owner_q)) : eligible;

    rr_arbiter_n #(.N(N_REQ), .NB(N_BITS_REQ)) u_arb (
        .req_i (arb_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    assign win_vc   = r_vc_id_i[arb_idx*N_BITS_VC +: N_BITS_VC];
    assign win_tail = r_tail_i[arb_idx];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        credit_d = credit_q;
        err_d    = err_q;

        if (arb_any) begin
            if (state_q == IDLE) begin
                rr_ptr_d = (arb_idx == N_BITS_REQ'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                if (!win_tail) begin
                    state_d = LOCKED;
                    owner_d = arb_idx;
                end
            end else if (win_tail) begin
                state_d = IDLE;
            end
        end

        for (int v = 0; v < N_TOT_OF_VC; v++) begin
            if (credit_signal_i[v] && !(arb_any && win_vc == N_BITS_VC'(v))) begin
                if (credit_q[v] == N_BITS_CREDIT'(MAX_CRED))
                    err_d = 1'b1;
                else
                    credit_d[v] = credit_q[v] + 1'b1;
            end else if (!credit_signal_i[v] && arb_any && win_vc == N_BITS_VC'(v)) begin
                credit_d[v] = credit_q[v] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            credit_q <= {N_TOT_OF_VC{N_BITS_CREDIT'(MAX_CRED)}};
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    // Grants are combinational, so mask them while reset is held.
    assign g_la_o         = arb_any & rst;
    assign g_onehot_o     = rst ? arb_gnt : '0;
    assign g_channel_id_o = rst ? arb_idx : '0;
    assign locked_o       = (state_q == LOCKED);
    assign credit_count_o = credit_q;
    assign credit_err_o   = err_q;

endmodule

// File: tb/tb_link_credit_scheduler.sv
// Self-checking bench for link_credit_scheduler: directed scenarios plus a
// randomized run, all compared against a behavioural model of the link rules.
module tb_link_credit_scheduler;

    localparam int NR = 4;
    localparam int NV = 6;
    localparam int MAXC = 4;
    localparam logic [17:0] ALL4 = {6{3'd4}};

    logic        clk, rst;
    logic [3:0]  r_la_i, r_tail_i, g_onehot_o;
    logic [11:0] r_vc_id_i;
    logic [5:0]  credit_signal_i;
    logic        g_la_o, locked_o, credit_err_o;
    logic [1:0]  g_channel_id_o;
    logic [17:0] credit_count_o;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int m_cred[NV];
    int m_rr, m_owner;
    bit m_locked, m_err;

    link_credit_scheduler dut (
        .clk(clk), .rst(rst),
        .r_la_i(r_la_i), .r_vc_id_i(r_vc_id_i), .r_tail_i(r_tail_i),
        .credit_signal_i(credit_signal_i),
        .g_la_o(g_la_o), .g_channel_id_o(g_channel_id_o), .g_onehot_o(g_onehot_o),
        .locked_o(locked_o), .credit_count_o(credit_count_o), .credit_err_o(credit_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int vc_of(input int i);
        return int'(r_vc_id_i[i*3 +: 3]);
    endfunction

    function automatic bit elig(input int i);
        int v;
        v = vc_of(i);
        return r_la_i[i] && v < NV && m_cred[v] > 0;
    endfunction

    // -1 when nobody can be granted this cycle
    function automatic int m_winner();
        int i;
        if (m_locked) return elig(m_owner) ? m_owner : -1;
        for (int k = 0; k < NR; k++) begin
            i = (m_rr + k) % NR;
            if (elig(i)) return i;
        end
        return -1;
    endfunction

    function automatic logic [26:0] m_expect();
        int w;
        logic [17:0] c;
        logic [3:0] oh;
        logic [1:0] id;
        logic g;
        w = m_winner();
        g = (w >= 0);
        oh = '0;
        id = '0;
        if (g) begin
            oh[w] = 1'b1;
            id = 2'(w);
        end
        for (int v = 0; v < NV; v++) c[v*3 +: 3] = 3'(m_cred[v]);
        return {g, id, oh, m_locked, m_err, c};
    endfunction

    function automatic void m_reset();
        for (int v = 0; v < NV; v++) m_cred[v] = MAXC;
        m_rr = 0; m_owner = 0; m_locked = 0; m_err = 0;
    endfunction

    function automatic void m_commit();
        int w, gv;
        w = m_winner();
        gv = (w >= 0) ? vc_of(w) : -1;
        for (int v = 0; v < NV; v++) begin
            if (credit_signal_i[v] && gv != v) begin
                if (m_cred[v] == MAXC) m_err = 1;
                else m_cred[v]++;
            end else if (!credit_signal_i[v] && gv == v) begin
                m_cred[v]--;
            end
        end
        if (w >= 0) begin
            if (!m_locked) m_rr = (w + 1) % NR;
            m_locked = !r_tail_i[w];
            m_owner = w;
        end
    endfunction

    // advance one clock; inputs are held between posedge+1 and next posedge
    task automatic tick();
        m_commit();
        @(posedge clk);
        #1;
        credit_signal_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        r_la_i = '0; r_tail_i = '0; r_vc_id_i = '0; credit_signal_i = '0;
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        r_la_i = 4'b1111; r_tail_i = 4'b1111; r_vc_id_i = {3'd3, 3'd2, 3'd1, 3'd0};
        credit_signal_i = '0;
        m_reset();
        #1;
        n_vec++;
        if ({g_la_o, g_channel_id_o, g_onehot_o, locked_o, credit_err_o} !== 9'b0 || credit_count_o !== ALL4) begin
            n_err++;
            $display("FAIL reset_outputs got la=%b id=%0d oh=%b lk=%b err=%b cred=%h want all zero, cred=%h",
                     g_la_o, g_channel_id_o, g_onehot_o, locked_o, credit_err_o, credit_count_o, ALL4);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (g_la_o !== 1'b0 || credit_count_o !== ALL4) begin
            n_err++;
            $display("FAIL reset_held_edge got la=%b cred=%h want 0 %h", g_la_o, credit_count_o, ALL4);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (g_la_o !== 1'b1 || g_channel_id_o !== 2'd0) begin
            n_err++;
            $display("FAIL reset_first_grant got la=%b id=%0d want 1 0", g_la_o, g_channel_id_o);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [17:0] exp_c;
        do_reset();
        r_vc_id_i = {3'd3, 3'd2, 3'd1, 3'd0}; r_tail_i = 4'b1111; r_la_i = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_vec++;
            if (g_la_o !== 1'b1 || g_channel_id_o !== 2'(c % 4)) begin
                n_err++;
                $display("FAIL rr_order cyc%0d got la=%b id=%0d want 1 %0d", c, g_la_o, g_channel_id_o, c % 4);
            end
            n_vec++;
            if ({g_la_o, g_channel_id_o, g_onehot_o, locked_o, credit_err_o, credit_count_o} !== m_expect()) begin
                n_err++;
                $display("FAIL rr_model cyc%0d got %h want %h", c,
                         {g_la_o, g_channel_id_o, g_onehot_o, locked_o, credit_err_o, credit_count_o}, m_expect());
            end
            tick();
        end
        r_la_i = '0;
        exp_c = {3'd4, 3'd4, 3'd3, 3'd3, 3'd3, 3'd2};
        #1;
        n_vec++;
        if (credit_count_o !== exp_c) begin
            n_err++;
            $display("FAIL rr_credits got %h want %h", credit_count_o, exp_c);
        end
        tick();
    endtask

    task automatic test_wormhole();
        logic [1:0] exp_id[4];
        exp_id = '{2'd2, 2'd2, 2'd2, 2'd0};
        do_reset();
        r_vc_id_i = {3'd3, 3'd2, 3'd1, 3'd0}; r_tail_i = 4'b1011; r_la_i = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) r_la_i = 4'b0111;
            if (c == 2) r_tail_i = 4'b1111;
            if (c == 3) r_la_i = 4'b0011;
            #1;
            n_vec++;
            if (g_la_o !== 1'b1 || g_channel_id_o !== exp_id[c] || locked_o !== (c == 1 || c == 2)) begin
                n_err++;
                $display("FAIL wormhole cyc%0d got la=%b id=%0d lk=%b want 1 %0d %b", c, g_la_o,
                         g_channel_id_o, locked_o, exp_id[c], (c == 1 || c == 2));
            end
            n_vec++;
            if ({g_la_o, g_channel_id_o, g_onehot_o, locked_o, credit_err_o, credit_count_o} !== m_expect()) begin
                n_err++;
                $display("FAIL wormhole_model cyc%0d got %h want %h", c,
                         {g_la_o, g_channel_id_o, g_onehot_o, locked_o, credit_err_o, credit_count_o}, m_expect());
            end
            tick();
        end
    endtask

    task automatic test_credit_stall();
        bit exp_g[8];
        exp_g = '{1, 1, 1, 1, 0, 0, 1, 0};
        do_reset();
        r_vc_id_i = {3'd0, 3'd0, 3'd5, 3'd0}; r_tail_i = 4'b1111; r_la_i = 4'b0010;
        for (int c = 0; c < 8; c++) begin
            if (c == 5) credit_signal_i = 6'b100000;
            #1;
            n_vec++;
            if (g_la_o !== exp_g[c] || (exp_g[c] && g_channel_id_o !== 2'd1)) begin
                n_err++;
                $display("FAIL credit_stall cyc%0d got la=%b id=%0d want %b 1", c, g_la_o, g_channel_id_o, exp_g[c]);
            end
            n_vec++;
            if ({g_la_o, g_channel_id_o, g_onehot_o, locked_o, credit_err_o, credit_count_o} !== m_expect()) begin
                n_err++;
                $display("FAIL credit_stall_model cyc%0d got %h want %h", c,
                         {g_la_o, g_channel_id_o, g_onehot_o, locked_o, credit_err_o, credit_count_o}, m_expect());
            end
            tick();
        end
    endtask

    task automatic test_credit_same_cycle();
        do_reset();
        r_vc_id_i = {3'd3, 3'd2, 3'd1, 3'd0}; r_tail_i = 4'b1111; r_la_i = 4'b0001;
        tick();
        tick();
        credit_signal_i = 6'b000001;
        #1;
        n_vec++;
        if (g_la_o !== 1'b1 || credit_count_o[2:0] !== 3'd2) begin
            n_err++;
            $display("FAIL same_cycle_pre got la=%b c0=%0d want 1 2", g_la_o, credit_count_o[2:0]);
        end
        tick();
        r_la_i = '0;
        #1;
        n_vec++;
        if (credit_count_o[2:0] !== 3'd2 || credit_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL same_cycle_net got c0=%0d err=%b want 2 0", credit_count_o[2:0], credit_err_o);
        end
        credit_signal_i = 6'b001000;
        tick();
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++;
            if (credit_count_o[11:9] !== 3'd4 || credit_err_o !== 1'b1) begin
                n_err++;
                $display("FAIL overflow_sticky cyc%0d got c3=%0d err=%b want 4 1", c, credit_count_o[11:9], credit_err_o);
            end
            tick();
        end
    endtask

    task automatic test_lock_stall();
        do_reset();
        r_vc_id_i = {3'd3, 3'd2, 3'd1, 3'd0}; r_tail_i = 4'b1011; r_la_i = 4'b0100;
        tick();
        r_la_i = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++;
            if (g_la_o !== 1'b0 || locked_o !== 1'b1) begin
                n_err++;
                $display("FAIL lock_stall cyc%0d got la=%b lk=%b want 0 1", c, g_la_o, locked_o);
            end
            tick();
        end
        r_la_i = 4'b0101; r_tail_i = 4'b1111;
        #1;
        n_vec++;
        if (g_la_o !== 1'b1 || g_channel_id_o !== 2'd2 || g_onehot_o !== 4'b0100) begin
            n_err++;
            $display("FAIL lock_resume got la=%b id=%0d oh=%b want 1 2 0100", g_la_o, g_channel_id_o, g_onehot_o);
        end
        tick();
        r_la_i = 4'b0001;
        #1;
        n_vec++;
        if (locked_o !== 1'b0 || g_channel_id_o !== 2'd0 || g_la_o !== 1'b1) begin
            n_err++;
            $display("FAIL lock_release got lk=%b la=%b id=%0d want 0 1 0", locked_o, g_la_o, g_channel_id_o);
        end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        r_vc_id_i = {3'd3, 3'd2, 3'd1, 3'd0}; r_tail_i = 4'b0000; r_la_i = 4'b0010;
        tick();
        #1;
        n_vec++;
        if (locked_o !== 1'b1 || g_la_o !== 1'b1) begin
            n_err++;
            $display("FAIL async_pre got lk=%b la=%b want 1 1", locked_o, g_la_o);
        end
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (g_la_o !== 1'b0 || g_onehot_o !== 4'b0 || g_channel_id_o !== 2'd0 || locked_o !== 1'b0
            || credit_count_o !== ALL4) begin
            n_err++;
            $display("FAIL async_reset got la=%b oh=%b id=%0d lk=%b cred=%h want 0 0 0 0 %h",
                     g_la_o, g_onehot_o, g_channel_id_o, locked_o, credit_count_o, ALL4);
        end
        r_la_i = '0;
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int gw;
        int r;
        do_reset();
        gw = -1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (i == gw || !r_la_i[i]) begin
                    r_la_i[i] = ($urandom_range(0, 3) != 0);
                    r_tail_i[i] = $urandom_range(0, 1) != 0;
                    // an owner mid-packet keeps its VC so the packet can finish
                    if (!(m_locked && m_owner == i)) begin
                        r = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
                        r_vc_id_i[i*3 +: 3] = 3'(r);
                    end
                end
            end
            for (int v = 0; v < NV; v++) credit_signal_i[v] = ($urandom_range(0, 5) == 0);
            #1;
            n_vec++;
            if ({g_la_o, g_channel_id_o, g_onehot_o, locked_o, credit_err_o, credit_count_o} !== m_expect()) begin
                n_err++;
                $display("FAIL random cyc%0d got %h want %h", c,
                         {g_la_o, g_channel_id_o, g_onehot_o, locked_o, credit_err_o, credit_count_o}, m_expect());
            end
            gw = m_winner();
            tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        r_la_i = '0; r_tail_i = '0; r_vc_id_i = '0; credit_signal_i = '0;
        m_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_wormhole();
        test_credit_stall();
        test_credit_same_cycle();
        test_lock_stall();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
